// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the 8-bit ALU: it holds the operand register file, issues one
// registered op per command and writes the result back. Define OP_COUNT_EN to add the op_count output.
module alu_op_sequencer #(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_src_a,
  input  logic [AW-1:0]    cmd_src_b,
  input  logic [AW-1:0]    cmd_dst,
  input  logic             rf_we,
  input  logic [AW-1:0]    rf_waddr,
  input  logic [WIDTH-1:0] rf_wdata,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c_out,
  input  logic             alu_zero,
  input  logic             alu_negative,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             done
`ifdef OP_COUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     rf [NREG];
  logic [AW-1:0]        dst_q;
  logic                 accept;
  logic                 writeback;

  // NOTE: state and storage use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: default assignment first, so no path through the case leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
  end

  assign accept    = cmd_ready && cmd_valid;
  assign writeback = (state_q == EXEC);

  // Operand reads happen at the same edge as any host load, so the ALU sees pre-load contents.
  // NOTE: the register file is deliberately reset; it is small and must read back as zero after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf          <= '{default: '0};
      dst_q       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= writeback;
      if (accept) begin
        alu_a       <= rf[cmd_src_a];
        alu_b       <= rf[cmd_src_b];
        alu_control <= cmd_op;
        dst_q       <= cmd_dst;
      end
      if (writeback) begin
        rf[dst_q] <= alu_result;
        flag_c    <= alu_c_out;
        flag_z    <= alu_zero;
        flag_n    <= alu_negative;
      end else if (rf_we) begin
        rf[rf_waddr] <= rf_wdata;
      end
    end
  end

  assign rd_data = rf[rd_addr];

`ifdef OP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)            op_count <= '0;
    else if (writeback) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side controller for the team's 8-bit ALU: the initiator end of the ALU operand/result interface.
- Holds a small operand register file and accepts commands (op, two sources, one destination) over a valid/ready handshake.
- Drives registered operands and control to the ALU, captures result and flags one cycle later, and writes the result back.
- Sits between a host or microsequencer and the combinational ALU.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU.
- NREG, 4, register-file depth (power of 2, >=2); AW = $clog2(NREG) is derived.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high only in IDLE.
- cmd_op  input  2  ALU control code, passed verbatim.
- cmd_src_a  input  AW  register index for operand A.
- cmd_src_b  input  AW  register index for operand B.
- cmd_dst  input  AW  register index for the result.
- rf_we  input  1  host register load enable.
- rf_waddr  input  AW  host load address.
- rf_wdata  input  WIDTH  host load data.
- rd_addr  input  AW  debug read address.
- rd_data  output  WIDTH  combinational rf[rd_addr].
- alu_a  output  WIDTH  registered operand A to the ALU.
- alu_b  output  WIDTH  registered operand B to the ALU.
- alu_control  output  2  registered op to the ALU.
- alu_result  input  WIDTH  ALU result.
- alu_c_out  input  1  ALU carry/borrow.
- alu_zero  input  1  ALU zero flag.
- alu_negative  input  1  ALU negative flag.
- flag_c  output  1  captured carry of the last completed op.
- flag_z  output  1  captured zero flag of the last completed op.
- flag_n  output  1  captured negative flag of the last completed op.
- done  output  1  one-cycle pulse when a writeback completes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - Every rf entry = 0.
  - alu_a, alu_b, alu_control = 0.
  - flag_c, flag_z, flag_n = 0; done = 0.
- FSM states: IDLE and EXEC.
- IDLE:
  - cmd_ready = 1.
  - On an edge with cmd_valid=1, the command is accepted: alu_a <= rf[src_a], alu_b <= rf[src_b], alu_control <= cmd_op, state -> EXEC.
  - The cmd_* inputs are not re-sampled after acceptance.
- EXEC:
  - Lasts exactly one cycle; cmd_ready = 0.
  - The ALU settles during this cycle.
  - At the closing edge: rf[dst] <= alu_result; flag_c/z/n <= alu_c_out/zero/negative; done <= 1; state -> IDLE.
- Latency:
  - Operands are visible on alu_* the cycle after acceptance.
  - done is high 2 cycles after acceptance.
  - Maximum throughput is 1 op per 2 cycles.
  - A command accepted in the done cycle reads the updated rf, so there is no read-after-write hazard.
- alu_a, alu_b and alu_control hold their last values in IDLE.
- Flags hold until the next writeback.
- Host loads (rf_we):
  - Honoured only in IDLE; ignored in EXEC.
  - If a load and a command accept coincide, operands sample the pre-load contents (read-before-write) and the load still takes effect.
- src_a == src_b is legal.
- dst equal to a source is legal; the source is read before the writeback.
- rd_data always reflects the current rf; it is updated the cycle after a write.
- Reset asserted during EXEC: the op is aborted, there is no writeback, done stays 0, and rf is cleared.
- ALU control encoding for the bench: 0=ADD, 1=SUB (A-B), 2=AND, 3=OR.

Optional Feature:
- OP_COUNT_EN defined:
  - Adds output op_count [15:0], reset to 0.
  - Incremented at each writeback edge; wraps 16'hFFFF -> 0.
- OP_COUNT_EN undefined: no port and no counter logic.

Test Plan:
- Load r0=1, r1=2; cmd ADD src 0,1 dst 2 -> alu_a=1, alu_b=2, alu_control=0 next cycle; done 2 cycles after accept; rd r2=3; C=0, Z=0, N=0.
- Load r0=5, r1=3; SUB dst 3 -> r3=2, done pulse exactly 1 cycle wide, cmd_ready=0 during EXEC.
- Load r0=3, r1=3; SUB dst 0 -> r0=0, flag_z=1; hold cmd_valid continuously -> second op accepted in the done cycle and reads r0=0.
- In IDLE, rf_we (r1=8'h0F) in the same cycle as accept of AND r1,r1 -> operands use the old r1; r1=8'h0F afterwards. rf_we during EXEC -> ignored.
- Assert rst in the EXEC cycle -> no done, rf all 0, flags 0, cmd_ready=1 after reset release.
- OP_COUNT_EN: 3 ops -> op_count=3; preload 16'hFFFF via force -> one op wraps to 0.
